// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the seq_gen serial pattern transmitter.
package seq_gen_pkg;

    localparam int unsigned GAP_W = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        GAP   = 3'd2,
        DONE  = 3'd3
    } state_e;

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out shift register, MSB first, zero fill; load wins over shift.
module piso_shift #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] pdata,
    output logic             msb
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = pdata;
        end else if (shift) begin
            sr_d = {sr_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb = sr_q[WIDTH-1];

endmodule

// File: rtl/seq_gen.sv
// Serial pattern transmitter: sends a captured pattern MSB first, repeats+1 times
// with an optional idle gap between sends, then pulses done for one cycle.
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] repeats,
    input  logic [GAP_W-1:0] gap,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BIT_W = $clog2(WIDTH);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0] pat_q, pat_d;

    logic             sr_load;
    logic             sr_shift;
    logic             sr_from_input;
    logic [WIDTH-1:0] sr_pdata;
    logic             sr_msb;

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rep_d         = rep_q;
        gap_d         = gap_q;
        gap_cnt_d     = gap_cnt_q;
        pat_d         = pat_q;
        sr_load       = 1'b0;
        sr_shift      = 1'b0;
        sr_from_input = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d         = pattern;
                    rep_d         = repeats;
                    gap_d         = gap;
                    bit_cnt_d     = BIT_LAST;
                    sr_load       = 1'b1;
                    sr_from_input = 1'b1;
                    state_d       = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt_q == '0) begin
                    if (rep_q == '0) begin
                        sr_shift = 1'b1;
                        state_d  = DONE;
                    end else if (gap_q == '0) begin
                        // Back-to-back reload keeps w_valid high with no bubble.
                        sr_load   = 1'b1;
                        rep_d     = rep_q - CNT_W'(1);
                        bit_cnt_d = BIT_LAST;
                    end else begin
                        sr_shift  = 1'b1;
                        gap_cnt_d = gap_q - GAP_W'(1);
                        state_d   = GAP;
                    end
                end else begin
                    sr_shift  = 1'b1;
                    bit_cnt_d = bit_cnt_q - BIT_W'(1);
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    sr_load   = 1'b1;
                    rep_d     = rep_q - CNT_W'(1);
                    bit_cnt_d = BIT_LAST;
                    state_d   = SHIFT;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            rep_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            pat_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rep_q     <= rep_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            pat_q     <= pat_d;
        end
    end

    assign sr_pdata = sr_from_input ? pattern : pat_q;

    piso_shift #(
        .WIDTH(WIDTH)
    ) u_piso (
        .clk  (clk),
        .rst_n(rst_n),
        .load (sr_load),
        .shift(sr_shift),
        .pdata(sr_pdata),
        .msb  (sr_msb)
    );

    // Outputs decode registered state only, so nothing combinational reaches them from inputs.
    assign w       = (state_q == SHIFT) & sr_msb;
    assign w_valid = (state_q == SHIFT);
    assign busy    = (state_q == SHIFT) | (state_q == GAP);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: stimulus queues expected bits/done/busy lengths, a monitor checks them.
module tb_seq_gen;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] pattern = '0;
    logic [CNT_W-1:0] repeats = '0;
    logic [1:0]       gap = '0;
    logic             w, w_valid, busy, done;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int run = 0;

    logic [2:0] exp_q[$];   // {done, w_valid, w}
    int         busy_q[$];

    always #5 clk = ~clk;

    seq_gen #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .pattern(pattern),
        .repeats(repeats),
        .gap    (gap),
        .w      (w),
        .w_valid(w_valid),
        .busy   (busy),
        .done   (done)
    );

    task automatic chk(input string name, input int got, input int expv);
        tests++;
        if (got != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, expv, $time);
        end
    endtask

    // Monitor: pops one expected item per valid bit or done pulse.
    always @(negedge clk) begin
        logic [2:0] e;
        int         bl;
        if (!rst_n) begin
            run = 0;
        end else begin
            if (busy) begin
                run++;
            end else if (run > 0) begin
                if (busy_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL busy_len: got run of %0d with none expected", run);
                end else begin
                    bl = busy_q.pop_front();
                    chk("busy_len", run, bl);
                end
                run = 0;
            end
            if (w_valid || done) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got done=%0b w_valid=%0b w=%0b with empty queue",
                             done, w_valid, w);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_bits", int'({done, w_valid, w}), int'(e));
                end
            end
            if (busy && !w_valid) chk("gap_w_zero", int'(w), 0);
            if (done) begin
                chk("done_not_busy", int'(busy), 0);
                done_cnt++;
            end
        end
    end

    task automatic send(input logic [7:0] p, input logic [3:0] r, input logic [1:0] g, input int blen);
        @(negedge clk);
        pattern = p;
        repeats = r;
        gap     = g;
        start   = 1'b1;
        for (int i = 0; i <= int'(r); i++) begin
            for (int b = 7; b >= 0; b--) exp_q.push_back({1'b0, 1'b1, p[b]});
        end
        exp_q.push_back(3'b100);
        busy_q.push_back(blen);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("first_bit_latency", int'(w_valid), 1);
    endtask

    task automatic wait_done(input int target, input int limit);
        int n;
        n = 0;
        while (done_cnt < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt < target) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got %0d done pulses expected %0d", done_cnt, target);
        end
        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_w", int'(w), 0);
        chk("rst_w_valid", int'(w_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send(8'hB4, 4'd0, 2'd0, 8);
        wait_done(1, 40);

        send(8'hF0, 4'd2, 2'd0, 24);
        wait_done(2, 60);

        send(8'h81, 4'd1, 2'd3, 19);
        wait_done(3, 60);

        // start while busy and during the done cycle, with pattern changed to zero
        send(8'hB4, 4'd0, 2'd0, 8);
        repeat (2) @(negedge clk);
        pattern = 8'h00;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("saw_done_cycle", int'(done), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("ignored_start_busy", int'(busy), 0);
        chk("ignored_start_dones", done_cnt, 4);
        chk("queue_drained", exp_q.size(), 0);

        send(8'h00, 4'd0, 2'd0, 8);
        wait_done(5, 40);

        send(8'hA5, 4'd15, 2'd0, 128);
        wait_done(6, 200);

        send(8'hFF, 4'd0, 2'd0, 8);
        wait_done(7, 40);

        send(8'h3C, 4'd3, 2'd1, 35);
        wait_done(8, 80);

        // reset mid-transfer
        send(8'hF0, 4'd2, 2'd0, 24);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_w", int'(w), 0);
        chk("midrst_w_valid", int'(w_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        exp_q.delete();
        busy_q.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("no_done_after_rst", done_cnt, 8);
        chk("idle_after_rst", int'(busy), 0);

        send(8'hB4, 4'd0, 2'd0, 8);
        wait_done(9, 40);
        chk("busy_q_drained", busy_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
